// File: rtl/excess3_digit_serial_sequencer.sv
// excess3_digit_serial_sequencer: feeds an external Excess-3 adder one digit per clock,
// LSD first, chaining the carry and packing the result as Excess-3 and BCD.
module excess3_digit_serial_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] op_a,
    input  logic [4*DIGITS-1:0] op_b,
    input  logic                cin_in,
    output logic [3:0]          add_a,
    output logic [3:0]          add_b,
    output logic                add_cin,
    input  logic [3:0]          add_sum,
    input  logic                add_cout,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [4*DIGITS-1:0] result,
    output logic [4*DIGITS-1:0] bcd_result,
    output logic                cout_out
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, bcd_q, bcd_d;
    logic            carry_q, carry_d, cout_q, cout_d, err_q, err_d;
    logic            ops_ok;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (op_a[4*i+:4] < 4'd3 || op_a[4*i+:4] > 4'd12 ||
                op_b[4*i+:4] < 4'd3 || op_b[4*i+:4] > 4'd12)
                ops_ok = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start && ops_ok) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin_in;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = RUN;
                end else if (start) begin
                    err_d   = 1'b1;
                    res_d   = '0;
                    bcd_d   = '0;
                    cout_d  = 1'b0;
                    state_d = DONE;
                end
            end
            RUN: begin
                res_d[4*idx_q+:4] = add_sum;
                bcd_d[4*idx_q+:4] = add_sum - 4'd3;
                carry_d           = add_cout;
                idx_d             = idx_q + 1'b1;
                if (idx_q == IW'(DIGITS - 1)) begin
                    cout_d  = add_cout;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Adder inputs come only from registers, so they are stable across the RUN cycle.
    assign busy       = state_q == RUN;
    assign done       = state_q == DONE;
    assign add_a      = busy ? a_q[4*idx_q+:4] : 4'd3;
    assign add_b      = busy ? b_q[4*idx_q+:4] : 4'd3;
    assign add_cin    = busy ? carry_q : 1'b0;
    assign err        = err_q;
    assign result     = res_q;
    assign bcd_result = bcd_q;
    assign cout_out   = cout_q;
endmodule

// File: tb/tb_excess3_digit_serial_sequencer.sv
// tb_excess3_digit_serial_sequencer: directed cases checked against a decimal-arithmetic
// model every cycle, plus literal expectations per case.
module tb_excess3_digit_serial_sequencer;
    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 0, rst_n = 0, start = 0, cin_in = 0;
    logic [W-1:0] op_a = 16'h3333, op_b = 16'h3333;
    logic [3:0]   add_a, add_b, add_sum;
    logic         add_cin, add_cout, busy, done, err, cout_out;
    logic [W-1:0] result, bcd_result;
    int           checks = 0, fails = 0;

    excess3_digit_serial_sequencer #(.DIGITS(D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy), .done(done), .err(err), .result(result), .bcd_result(bcd_result),
        .cout_out(cout_out)
    );

    always #5 clk = ~clk;

    // Excess-3 single-digit adder
    int adder_s;
    assign adder_s  = (int'(add_a) - 3) + (int'(add_b) - 3) + int'(add_cin);
    assign add_cout = adder_s >= 10;
    assign add_sum  = 4'((adder_s % 10) + 3);

    function automatic int dec_val(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + (int'(v[4*i+:4]) - 3);
        return r;
    endfunction

    function automatic bit valid(input logic [W-1:0] v);
        bit ok = 1;
        for (int i = 0; i < D; i++) if (v[4*i+:4] < 3 || v[4*i+:4] > 12) ok = 0;
        return ok;
    endfunction

    function automatic logic [W-1:0] digits(input int n, input int bias);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i+:4] = 4'(n % 10 + bias);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic [D-1:0] carries(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int va = dec_val(a), vb = dec_val(b), p = 1;
        logic [D-1:0] r;
        for (int i = 0; i < D; i++) begin
            r[i] = (va % p + vb % p + int'(c)) >= p;
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Transaction-level model
    logic         m_busy, m_done, e_err, e_cout;
    int           m_k;
    logic [W-1:0] m_a, m_b, e_res, e_bcd;
    logic [D-1:0] m_car;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_k <= 0; e_err <= 0; e_cout <= 0;
            m_a <= '0; m_b <= '0; e_res <= '0; e_bcd <= '0; m_car <= '0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                m_k <= m_k + 1;
                if (m_k == D - 1) begin
                    m_busy <= 0;
                    m_done <= 1;
                end
            end else if (!m_done && start) begin
                if (!valid(op_a) || !valid(op_b)) begin
                    m_done <= 1; e_err <= 1; e_res <= '0; e_bcd <= '0; e_cout <= 0;
                end else begin
                    m_busy <= 1; m_k <= 0; e_err <= 0; m_a <= op_a; m_b <= op_b;
                    m_car  <= carries(op_a, op_b, cin_in);
                    e_res  <= digits((dec_val(op_a) + dec_val(op_b) + int'(cin_in)) % 10000, 3);
                    e_bcd  <= digits((dec_val(op_a) + dec_val(op_b) + int'(cin_in)) % 10000, 0);
                    e_cout <= (dec_val(op_a) + dec_val(op_b) + int'(cin_in)) >= 10000;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("err", err, e_err);
        chk("add_a", add_a, m_busy ? m_a[4*m_k+:4] : 4'd3);
        chk("add_b", add_b, m_busy ? m_b[4*m_k+:4] : 4'd3);
        chk("add_cin", add_cin, m_busy ? m_car[m_k] : 1'b0);
        if (!m_busy) begin
            chk("result", result, e_res);
            chk("bcd_result", bcd_result, e_bcd);
            chk("cout_out", cout_out, e_cout);
        end
    end

    task automatic run_case(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic [W-1:0] xr, input logic [W-1:0] xb,
                            input logic xc, input logic xe);
        int n = 0;
        @(posedge clk);
        #2 op_a = a; op_b = b; cin_in = c; start = 1;
        @(posedge clk);
        #1 start = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk({nm, " latency"}, n, xe ? 0 : D);
        chk({nm, " result"}, result, xr);
        chk({nm, " bcd"}, bcd_result, xb);
        chk({nm, " cout"}, cout_out, xc);
        chk({nm, " err"}, err, xe);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " err"}, err, 0);
        chk({nm, " result"}, result, 0);
        chk({nm, " bcd"}, bcd_result, 0);
        chk({nm, " cout"}, cout_out, 0);
        chk({nm, " add_a"}, add_a, 4'd3);
        chk({nm, " add_b"}, add_b, 4'd3);
        chk({nm, " add_cin"}, add_cin, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 chk_reset_vals("reset");
        #1 rst_n = 1;
        run_case("c1", 16'h368B, 16'h3975, 0, 16'h4333, 16'h1000, 0, 0);
        run_case("c2", 16'hCCCC, 16'hCCCC, 1, 16'hCCCC, 16'h9999, 1, 0);
        run_case("c3", 16'h3333, 16'h3333, 1, 16'h3334, 16'h0001, 0, 0);
        run_case("c4", 16'h3330, 16'h3333, 0, 16'h0000, 16'h0000, 0, 1);
        run_case("c4b", 16'h3333, 16'h3333, 1, 16'h3334, 16'h0001, 0, 0);
        fork
            run_case("c5", 16'h368B, 16'h3975, 0, 16'h4333, 16'h1000, 0, 0);
            begin
                repeat (3) @(posedge clk);
                #2 start = 1; op_a = 16'hCCCC; op_b = 16'h4444;
                repeat (2) @(posedge clk);
                #2 start = 0;
            end
        join
        @(posedge clk);
        #2 op_a = 16'hCCCC; op_b = 16'hCCCC; cin_in = 1; start = 1;
        @(posedge clk);
        #1 start = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1 chk_reset_vals("c6 abort");
        @(posedge clk);
        #2 rst_n = 1;
        repeat (3) @(posedge clk);
        run_case("c6", 16'h368B, 16'h3975, 0, 16'h4333, 16'h1000, 0, 0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
